// File: rtl/ntt_stage_controller.sv
// ntt_stage_controller
// Sequences one ntt_core through a complete forward NTT: LOG_N in-place
// butterfly stages. Each stage streams DEPTH read addresses, waits for the
// butterfly pipeline to drain, then swaps the RAM banks.
//
// Ports
//   clk, rst_n            clock and asynchronous active-low reset
//   start                 one-cycle transform request, honoured only in IDLE
//   busy                  high while a transform is in flight (incl. DONE)
//   done                  one-cycle pulse after the final stage write-back
//   log_m, mode, i        stage index, twiddle mode and group index for the core
//   read_address          RAM word read address (upper bits always 0)
//   read_select           bank being read
//   write_select          bank being written (always ~read_select)
//   upper/lower_write_*   write strobes and addresses, delayed by WB_DELAY
module ntt_stage_controller #(
  parameter int LOG_N          = 12,
  parameter int LOG_CORE_COUNT = 5,
  parameter int BF_LATENCY     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [3:0] log_m,
  output logic [1:0] mode,
  output logic [9:0] i,
  output logic [8:0] read_address,
  output logic       read_select,
  output logic       write_select,
  output logic       upper_write_enable,
  output logic       lower_write_enable,
  output logic [8:0] upper_write_address,
  output logic [8:0] lower_write_address
);

  localparam int LOG_WORDS = LOG_N - LOG_CORE_COUNT - 2;
  localparam int WB_DELAY  = BF_LATENCY + 1;
  // Internal delay stages; the output register supplies the final one.
  localparam int PIPE      = WB_DELAY - 1;
  localparam int DW        = $clog2(WB_DELAY);

  localparam logic [LOG_WORDS-1:0] W_LAST     = '1;
  localparam logic [DW-1:0]        D_LAST     = DW'(WB_DELAY - 1);
  localparam logic [3:0]           LAST_STAGE = 4'(LOG_N - 1);
  localparam logic [3:0]           MODE1_LO   = 4'(LOG_CORE_COUNT);
  localparam logic [3:0]           MODE2_LO   = 4'(LOG_N - 2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DRAIN = 3'd2,
    S_NEXT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                state_r, state_s;
  logic [LOG_WORDS-1:0]  w_r, w_s;
  logic [DW-1:0]         drain_r, drain_s;
  logic [3:0]            log_m_s;

  logic                  busy_s, done_s, issue_s;
  logic [1:0]            mode_s;
  logic [9:0]            i_s;

  logic [PIPE-1:0]       vld_r;
  logic [LOG_WORDS-1:0]  wa_pipe_r [PIPE];

  // Twiddle addressing mode for a given stage.
  function automatic logic [1:0] mode_of(input logic [3:0] lm);
    logic [1:0] m;
    if (lm < MODE1_LO) begin
      m = 2'd0;
    end else if (lm < MODE2_LO) begin
      m = 2'd1;
    end else begin
      m = 2'd2;
    end
    return m;
  endfunction

  // Group index: the word counter shifted so that each group spans
  // 2**(LOG_WORDS-(lm-LOG_CORE_COUNT)) words; zero outside mode 1.
  function automatic logic [9:0] index_of(input logic [3:0] lm,
                                          input logic [LOG_WORDS-1:0] w);
    logic [4:0] sh;
    logic [9:0] idx;
    sh = 5'(LOG_WORDS) - (5'(lm) - 5'(LOG_CORE_COUNT));
    if (mode_of(lm) == 2'd1) begin
      idx = 10'(w) >> sh;
    end else begin
      idx = 10'd0;
    end
    return idx;
  endfunction

  // State, word counter, drain counter and stage index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      w_r     <= '0;
      drain_r <= '0;
      log_m   <= 4'd0;
    end else begin
      state_r <= state_s;
      w_r     <= w_s;
      drain_r <= drain_s;
      log_m   <= log_m_s;
    end
  end

  // Next-state and counter update logic.
  always_comb begin
    state_s = state_r;
    w_s     = w_r;
    drain_s = drain_r;
    log_m_s = log_m;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s = S_ISSUE;
          w_s     = '0;
          log_m_s = 4'd0;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (w_r == W_LAST) begin
          state_s = S_DRAIN;
          w_s     = '0;
          drain_s = '0;
        end else begin
          w_s = w_r + {{(LOG_WORDS-1){1'b0}}, 1'b1};
        end
      end
      S_DRAIN: begin
        if (drain_r == D_LAST) begin
          state_s = S_NEXT;
        end else begin
          drain_s = drain_r + {{(DW-1){1'b0}}, 1'b1};
        end
      end
      S_NEXT: begin
        if (log_m == LAST_STAGE) begin
          state_s = S_DONE;
        end else begin
          state_s = S_ISSUE;
          w_s     = '0;
          log_m_s = log_m + 4'd1;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state so registered outputs line up with it.
  always_comb begin
    busy_s  = (state_s != S_IDLE);
    done_s  = (state_s == S_DONE);
    issue_s = (state_s == S_ISSUE);
    mode_s  = mode_of(log_m_s);
    i_s     = index_of(log_m_s, w_s);
  end

  // Registered status and issue outputs; issue outputs hold outside ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      mode         <= 2'd0;
      i            <= 10'd0;
      read_address <= 9'd0;
    end else begin
      busy <= busy_s;
      done <= done_s;
      if (issue_s) begin
        mode         <= mode_s;
        i            <= i_s;
        read_address <= 9'(w_s);
      end else begin
        mode         <= mode;
        i            <= i;
        read_address <= read_address;
      end
    end
  end

  // Bank ping-pong: swap on leaving NEXT, so the new stage reads what the
  // previous stage just wrote.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_select  <= 1'b0;
      write_select <= 1'b1;
    end else if (state_r == S_NEXT) begin
      read_select  <= ~read_select;
      write_select <= read_select;
    end else begin
      read_select  <= read_select;
      write_select <= write_select;
    end
  end

  // Write-valid / write-address delay line matching the butterfly latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_r <= '0;
      for (int k = 0; k < PIPE; k++) begin
        wa_pipe_r[k] <= '0;
      end
    end else begin
      vld_r        <= {vld_r[PIPE-2:0], (state_r == S_ISSUE)};
      wa_pipe_r[0] <= read_address[LOG_WORDS-1:0];
      for (int k = 1; k < PIPE; k++) begin
        wa_pipe_r[k] <= wa_pipe_r[k-1];
      end
    end
  end

  // Write strobes and addresses; addresses hold between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upper_write_enable  <= 1'b0;
      lower_write_enable  <= 1'b0;
      upper_write_address <= 9'd0;
      lower_write_address <= 9'd0;
    end else begin
      upper_write_enable <= vld_r[PIPE-1];
      lower_write_enable <= vld_r[PIPE-1];
      if (vld_r[PIPE-1]) begin
        upper_write_address <= 9'(wa_pipe_r[PIPE-1]);
        lower_write_address <= 9'(wa_pipe_r[PIPE-1]);
      end else begin
        upper_write_address <= upper_write_address;
        lower_write_address <= lower_write_address;
      end
    end
  end

endmodule

// File: tb/tb_ntt_stage_controller.sv
// Directed bench for ntt_stage_controller with default parameters.
// Cycle 0 is the cycle in which start is driven high; outputs are sampled
// at the falling edge of each cycle and compared against a cycle model
// derived from the stage timing (38 cycles per stage: 32 issue, 5 drain, 1 next).
module tb_ntt_stage_controller;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       busy, done;
  logic [3:0] log_m;
  logic [1:0] mode;
  logic [9:0] i;
  logic [8:0] read_address;
  logic       read_select, write_select;
  logic       upper_write_enable, lower_write_enable;
  logic [8:0] upper_write_address, lower_write_address;

  int tests_run = 0;
  int tests_failed = 0;

  // model state carried between runs
  logic [8:0] m_ra, m_wa;
  logic [1:0] m_mode;
  logic [9:0] m_i;
  logic       m_sel;

  // observations of the most recent run
  int   done_count, done_cycle, strobe_count, toggle_count, busy_first;
  logic [1:0] mode_seen [12];
  logic [9:0] i_l6_w16, i_l7_w8, i_l7_w16, i_l7_w24;
  bit   aborted;

  ntt_stage_controller dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy), .done(done), .log_m(log_m), .mode(mode), .i(i),
    .read_address(read_address), .read_select(read_select),
    .write_select(write_select),
    .upper_write_enable(upper_write_enable),
    .lower_write_enable(lower_write_enable),
    .upper_write_address(upper_write_address),
    .lower_write_address(lower_write_address)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_ra = 9'd0; m_wa = 9'd0; m_mode = 2'd0; m_i = 10'd0; m_sel = 1'b0;
  endtask

  // Drives one transform and checks every cycle against the model.
  task automatic run_transform(input int pulse_cyc, input int abort_cyc, input string tag);
    logic [48:0] act, exp;
    logic        prev_rs;
    logic        e_busy, e_done, e_we;
    logic [3:0]  e_log;
    logic        e_rs;
    int          s, off;
    done_count = 0; done_cycle = -1; strobe_count = 0; toggle_count = 0;
    busy_first = -1; aborted = 1'b0;
    @(negedge clk);
    start = 1'b1;
    prev_rs = read_select;
    for (int n = 1; n <= 460; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n == pulse_cyc) start = 1'b1;
      if (n == pulse_cyc + 1) start = 1'b0;
      if (n == abort_cyc) begin
        rst_n = 1'b0;
        #1;
        aborted = 1'b1;
        model_reset();
        act = {busy, done, log_m, mode, i, read_address, read_select, write_select,
               upper_write_enable, lower_write_enable, upper_write_address, lower_write_address};
        exp = {1'b0, 1'b0, 4'd0, 2'd0, 10'd0, 9'd0, 1'b0, 1'b1, 1'b0, 1'b0, 9'd0, 9'd0};
        tests_run++;
        if (act !== exp) begin
          tests_failed++;
          $display("FAIL %s abort_reset_values: got %h expected %h", tag, act, exp);
        end
        break;
      end
      s = (n - 1) / 38;
      off = (n - 1) % 38;
      e_we = 1'b0;
      if (n <= 456) begin
        e_busy = 1'b1; e_done = 1'b0; e_log = 4'(s);
        e_rs = m_sel ^ s[0];
        if (off < 32) begin
          m_ra = 9'(off);
          m_mode = (s < 5) ? 2'd0 : ((s < 10) ? 2'd1 : 2'd2);
          m_i = (m_mode == 2'd1) ? 10'(off >> (10 - s)) : 10'd0;
          if (off == 0) mode_seen[s] = mode;
        end
        if (off >= 5 && off <= 36) begin
          e_we = 1'b1;
          m_wa = 9'(off - 5);
        end
        if (s == 6 && off == 16) i_l6_w16 = i;
        if (s == 7 && off == 8)  i_l7_w8  = i;
        if (s == 7 && off == 16) i_l7_w16 = i;
        if (s == 7 && off == 24) i_l7_w24 = i;
      end else begin
        e_busy = (n == 457); e_done = (n == 457); e_log = 4'd11;
        e_rs = m_sel;
      end
      exp = {e_busy, e_done, e_log, m_mode, m_i, m_ra, e_rs, ~e_rs, e_we, e_we, m_wa, m_wa};
      act = {busy, done, log_m, mode, i, read_address, read_select, write_select,
             upper_write_enable, lower_write_enable, upper_write_address, lower_write_address};
      tests_run++;
      if (act !== exp) begin
        tests_failed++;
        $display("FAIL %s cycle_%0d outputs: got %h expected %h", tag, n, act, exp);
      end
      if (done) begin done_count++; done_cycle = n; end
      if (upper_write_enable) strobe_count++;
      if (busy && busy_first < 0) busy_first = n;
      if (read_select !== prev_rs) toggle_count++;
      prev_rs = read_select;
    end
  endtask

  task automatic check_full_run(input string tag);
    tests_run++;
    if (busy_first != 1) begin
      tests_failed++;
      $display("FAIL %s busy_rise: got cycle %0d expected 1", tag, busy_first);
    end
    tests_run++;
    if (done_count != 1 || done_cycle != 457) begin
      tests_failed++;
      $display("FAIL %s done_pulse: got %0d pulses last at %0d expected 1 at 457", tag, done_count, done_cycle);
    end
    tests_run++;
    if (toggle_count != 12) begin
      tests_failed++;
      $display("FAIL %s bank_toggles: got %0d expected 12", tag, toggle_count);
    end
    tests_run++;
    if (strobe_count != 384) begin
      tests_failed++;
      $display("FAIL %s write_strobes: got %0d expected 384", tag, strobe_count);
    end
  endtask

  task automatic test_reset();
    logic [48:0] act, exp;
    rst_n = 1'b0; start = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    act = {busy, done, log_m, mode, i, read_address, read_select, write_select,
           upper_write_enable, lower_write_enable, upper_write_address, lower_write_address};
    exp = {1'b0, 1'b0, 4'd0, 2'd0, 10'd0, 9'd0, 1'b0, 1'b1, 1'b0, 1'b0, 9'd0, 9'd0};
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL reset_values: got %h expected %h", act, exp);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || upper_write_enable !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: busy=%b done=%b we=%b expected 0 0 0", busy, done, upper_write_enable);
    end
  endtask

  task automatic test_full_run();
    run_transform(-10, -10, "full_run");
    check_full_run("full_run");
  endtask

  task automatic test_mode_index();
    logic [1:0] exp_mode [12];
    exp_mode = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2};
    for (int s = 0; s < 12; s++) begin
      tests_run++;
      if (mode_seen[s] !== exp_mode[s]) begin
        tests_failed++;
        $display("FAIL mode_stage_%0d: got %0d expected %0d", s, mode_seen[s], exp_mode[s]);
      end
    end
    tests_run++;
    if (i_l6_w16 !== 10'd1 || i_l7_w8 !== 10'd1 || i_l7_w16 !== 10'd2 || i_l7_w24 !== 10'd3) begin
      tests_failed++;
      $display("FAIL group_index: got %0d %0d %0d %0d expected 1 1 2 3",
               i_l6_w16, i_l7_w8, i_l7_w16, i_l7_w24);
    end
  endtask

  task automatic test_start_ignored();
    run_transform(100, -10, "start_ignored");
    check_full_run("start_ignored");
  endtask

  task automatic test_abort();
    int strobes_after, dones_after;
    // cycle 225 is in the drain phase of stage 5
    run_transform(-10, 225, "abort");
    tests_run++;
    if (!aborted) begin
      tests_failed++;
      $display("FAIL abort_reached: got 0 expected 1");
    end
    strobes_after = 0; dones_after = 0;
    for (int n = 0; n < 13; n++) begin
      @(negedge clk);
      if (n == 3) rst_n = 1'b1;
      if (upper_write_enable || lower_write_enable) strobes_after++;
      if (done || busy) dones_after++;
    end
    tests_run++;
    if (strobes_after != 0 || dones_after != 0) begin
      tests_failed++;
      $display("FAIL abort_quiet: got %0d strobes %0d busy/done expected 0 0", strobes_after, dones_after);
    end
  endtask

  task automatic test_restart();
    run_transform(-10, -10, "restart");
    check_full_run("restart");
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    test_reset();
    test_full_run();
    test_mode_index();
    test_start_ignored();
    test_abort();
    test_restart();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
